// File: rtl/chan_router_pkg.sv
// chan_router_pkg: shared types and constants for the chan_router block.
// Contents: sel_w() lane-index width derivation, state_e FSM encoding,
// STATS_W per-destination transfer counter width.
package chan_router_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

    localparam int STATS_W = 8;

    // Index width for n lanes; never below one bit so a 2-lane router still has a select.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chan_router_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i.
// Ports:
//   req_i   [CHANNELS]  request vector
//   ptr_i   [SELW]      lane with highest priority this cycle
//   grant_o [CHANNELS]  one-hot grant (zero when no request)
//   idx_o   [SELW]      index of the granted lane
//   any_o               at least one request present
module rr_arbiter
    import chan_router_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int SELW = sel_w(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SELW-1:0]     ptr_i,
    output logic [CHANNELS-1:0] grant_o,
    output logic [SELW-1:0]     idx_o,
    output logic                any_o
);

    logic [SELW-1:0] j;

    // CHANNELS is a power of two, so the SELW-bit add wraps modulo CHANNELS for free.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            j = ptr_i + SELW'(k);
            if (!any_o && req_i[j]) begin
                grant_o[j] = 1'b1;
                idx_o      = j;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_router.sv
// chan_router: round-robin N:N lane router with a one-entry holding register.
// Ports:
//   clk, rst (async, active high), enable (low blocks grants and blanks outputs)
//   in_data/in_dest/in_valid -> in_ready : source lanes, lane i at [i*W +: W]
//   out_data/out_valid <- out_ready      : destination lanes, only lane dest_q is driven
//   stats_clr, xfer_count                : only with CHAN_ROUTER_STATS_EN defined,
//                                          8-bit wrapping drain counter per destination
module chan_router
    import chan_router_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CHANNELS = 4,
    localparam int SELW = sel_w(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS*SELW-1:0] in_dest,
    input  logic [CHANNELS-1:0]      in_valid,
    output logic [CHANNELS-1:0]      in_ready,
`ifdef CHAN_ROUTER_STATS_EN
    input  logic                     stats_clr,
    output logic [CHANNELS*STATS_W-1:0] xfer_count,
`endif
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]      out_valid,
    input  logic [CHANNELS-1:0]      out_ready
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SELW-1:0]   dest_q, dest_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [CHANNELS-1:0] grant;
    logic [SELW-1:0]   win;
    logic              any;
    logic              drain, capture;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .req_i   (in_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win),
        .any_o   (any)
    );

    // A drain frees the register in the same cycle, so a new word can follow back-to-back.
    assign drain   = (state_q == FULL) && enable && out_ready[dest_q];
    assign capture = enable && any && ((state_q == IDLE) || drain);
    assign in_ready = capture ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = capture ? FULL : (drain ? IDLE : state_q);
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((state_q == FULL) && enable && (dest_q == SELW'(i))) begin
                out_valid[i]                 = 1'b1;
                out_data[i*WIDTH +: WIDTH]   = data_q;
            end
        end
    end

    always_comb begin
        data_d = data_q;
        dest_d = dest_q;
        ptr_d  = ptr_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (capture && (win == SELW'(i))) begin
                data_d = in_data[i*WIDTH +: WIDTH];
                dest_d = in_dest[i*SELW +: SELW];
            end
        end
        if (capture) ptr_d = win + SELW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            dest_q <= '0;
            ptr_q  <= '0;
        end else begin
            data_q <= data_d;
            dest_q <= dest_d;
            ptr_q  <= ptr_d;
        end
    end

`ifdef CHAN_ROUTER_STATS_EN
    logic [CHANNELS-1:0][STATS_W-1:0] cnt_q;

    // Clear has priority over a coincident drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            cnt_q <= '0;
        else if (stats_clr) cnt_q <= '0;
        else if (drain)     cnt_q[dest_q] <= cnt_q[dest_q] + STATS_W'(1);
    end

    assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_chan_router.sv
// tb_chan_router: self-checking bench for chan_router (CHANNELS=4, WIDTH=4).
module tb_chan_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] in_data;
    logic [7:0]  in_dest;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [15:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
`ifdef CHAN_ROUTER_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] xfer_count;
`endif

    int errors = 0;
    int checks = 0;

    chan_router #(.WIDTH(4), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef CHAN_ROUTER_STATS_EN
        .stats_clr (stats_clr),
        .xfer_count(xfer_count),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        en;
        logic [3:0]  v;
        logic [15:0] d;
        logic [7:0]  dst;
        logic [3:0]  ordy;
        logic [3:0]  e_ir;
        logic [3:0]  e_ov;
        logic [15:0] e_od;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic en, input logic [3:0] v, input logic [15:0] d,
                       input logic [7:0] dst, input logic [3:0] ordy,
                       input logic [3:0] e_ir, input logic [3:0] e_ov, input logic [15:0] e_od);
        enable = en; in_valid = v; in_data = d; in_dest = dst; out_ready = ordy;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".out_data"}, 32'(out_data), 32'(e_od));
        @(posedge clk);
        #1;
    endtask

    // Reference model state: the held word as a plain record plus an integer pointer.
    bit       m_full;
    int       m_word, m_dest, m_ptr;

    initial begin
        rst = 1'b1; enable = 1'b0; in_valid = '0; in_data = '0; in_dest = '0; out_ready = '0;
        #2;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_data", 32'(out_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single transfer, then fairness (entries with r=1 start from a fresh reset)
        tbl[0]  = '{1'b1, 1'b1, 4'h0, 16'h0000, 8'h00, 4'hF, 4'h0, 4'h0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 4'h2, 16'h00A0, 8'h08, 4'hF, 4'h2, 4'h0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 8'h00, 4'hF, 4'h0, 4'h4, 16'h0A00};
        tbl[3]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 8'h00, 4'hF, 4'h0, 4'h0, 16'h0000};
        tbl[4]  = '{1'b1, 1'b1, 4'hF, 16'h4321, 8'h00, 4'hF, 4'h1, 4'h0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 4'hF, 16'h4321, 8'h00, 4'hF, 4'h2, 4'h1, 16'h0001};
        tbl[6]  = '{1'b0, 1'b1, 4'hF, 16'h4321, 8'h00, 4'hF, 4'h4, 4'h1, 16'h0002};
        tbl[7]  = '{1'b0, 1'b1, 4'hF, 16'h4321, 8'h00, 4'hF, 4'h8, 4'h1, 16'h0003};
        tbl[8]  = '{1'b0, 1'b1, 4'hF, 16'h4321, 8'h00, 4'hF, 4'h1, 4'h1, 16'h0004};
        tbl[9]  = '{1'b0, 1'b1, 4'h0, 16'h4321, 8'h00, 4'hF, 4'h0, 4'h1, 16'h0001};
        tbl[10] = '{1'b0, 1'b1, 4'h0, 16'h0000, 8'h00, 4'hF, 4'h0, 4'h0, 16'h0000};
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].r) do_reset();
            cyc($sformatf("vec%0d", i), tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].dst, tbl[i].ordy,
                tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_od);
        end

        // backpressure: src0 -> dest3 held 5 cycles while src2 waits
        do_reset();
        cyc("bp.cap", 1, 4'h1, 16'h0005, 8'h03, 4'h7, 4'h1, 4'h0, 16'h0000);
        for (int i = 0; i < 5; i++)
            cyc($sformatf("bp.hold%0d", i), 1, 4'h4, 16'h0705, 8'h13, 4'h7, 4'h0, 4'h8, 16'h5000);
        cyc("bp.swap", 1, 4'h4, 16'h0705, 8'h13, 4'hF, 4'h4, 4'h8, 16'h5000);
        cyc("bp.src2", 1, 4'h0, 16'h0000, 8'h00, 4'hF, 4'h0, 4'h2, 16'h0070);
        cyc("bp.idle", 1, 4'h0, 16'h0000, 8'h00, 4'hF, 4'h0, 4'h0, 16'h0000);

        // enable drop while holding 4'hC for dest1
        do_reset();
        cyc("en.cap", 1, 4'h2, 16'h00C0, 8'h04, 4'h0, 4'h2, 4'h0, 16'h0000);
        cyc("en.off0", 0, 4'h1, 16'h0000, 8'h00, 4'hF, 4'h0, 4'h0, 16'h0000);
        cyc("en.off1", 0, 4'h1, 16'h0000, 8'h00, 4'hF, 4'h0, 4'h0, 16'h0000);
        cyc("en.back", 1, 4'h0, 16'h0000, 8'h00, 4'h0, 4'h0, 4'h2, 16'h00C0);
        cyc("en.drain", 1, 4'h0, 16'h0000, 8'h00, 4'hF, 4'h0, 4'h2, 16'h00C0);
        cyc("en.idle", 1, 4'h0, 16'h0000, 8'h00, 4'hF, 4'h0, 4'h0, 16'h0000);

        // async reset mid-transfer; pointer must restart at src0
        do_reset();
        cyc("ar.cap", 1, 4'h1, 16'h0009, 8'h00, 4'h0, 4'h1, 4'h0, 16'h0000);
        in_valid = 4'h0;
        @(negedge clk);
        chk("ar.full", 32'(out_valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("ar.rst_valid", 32'(out_valid), 0);
        chk("ar.rst_data", 32'(out_data), 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("ar.ptr", 1, 4'hF, 16'h4321, 8'h00, 4'hF, 4'h1, 4'h0, 16'h0000);

        // randomized traffic against a record-level model
        do_reset();
        m_full = 0; m_word = 0; m_dest = 0; m_ptr = 0;
        for (int n = 0; n < 400; n++) begin
            int w, e_ir, e_ov, e_od;
            bit drn, cap;
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = 4'($urandom);
            in_data   = 16'($urandom);
            in_dest   = 8'($urandom);
            out_ready = 4'($urandom);
            drn = m_full && enable && out_ready[m_dest];
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && in_valid[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            cap = enable && (w >= 0) && (!m_full || drn);
            e_ir = cap ? (1 << w) : 0;
            e_ov = (m_full && enable) ? (1 << m_dest) : 0;
            e_od = (m_full && enable) ? (m_word << (4 * m_dest)) : 0;
            @(negedge clk);
            chk($sformatf("rnd%0d.in_ready", n), 32'(in_ready), 32'(e_ir));
            chk($sformatf("rnd%0d.out_valid", n), 32'(out_valid), 32'(e_ov));
            chk($sformatf("rnd%0d.out_data", n), 32'(out_data), 32'(e_od));
            if (cap) begin
                m_full = 1;
                m_word = (in_data >> (4 * w)) & 'hF;
                m_dest = (in_dest >> (2 * w)) & 'h3;
                m_ptr  = (w + 1) % 4;
            end else if (drn) begin
                m_full = 0;
            end
            @(posedge clk);
            #1;
        end

`ifdef CHAN_ROUTER_STATS_EN
        do_reset();
        enable = 1; in_valid = 4'h1; in_data = 16'h0006; in_dest = 8'h02; out_ready = 4'hF;
        repeat (300) @(posedge clk);
        #1 in_valid = 4'h0;
        @(posedge clk);
        @(negedge clk);
        chk("stats.wrap", xfer_count, 32'h002C_0000);
        stats_clr = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        @(negedge clk);
        chk("stats.clr", xfer_count, 32'h0);
        in_valid = 4'h1;
        @(posedge clk);
        #1 in_valid = 4'h0; stats_clr = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        @(negedge clk);
        chk("stats.clr_wins", xfer_count, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
